// File: rtl/axis_pingpong_merge.sv
// Merges two AXI-stream result channels into one registered output, alternating
// whole packets between input 0 and input 1, with packet-length diagnostics.
module axis_pingpong_merge #(
  parameter int unsigned N  = 16,
  parameter int unsigned QW = 64,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          s_rst_n,
  input  logic [QW-1:0] s0_data,
  input  logic          s0_vld,
  input  logic          s0_last,
  output logic          s0_rdy,
  input  logic [QW-1:0] s1_data,
  input  logic          s1_vld,
  input  logic          s1_last,
  output logic          s1_rdy,
  output logic [QW-1:0] m_data,
  output logic          m_vld,
  output logic          m_last,
  input  logic          m_rdy,
  output logic          sel,
  output logic          err_len,
  output logic [CW-1:0] pkt_cnt
);

  localparam int unsigned BW = $clog2(N) + 1;

  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_cnt, beat_cnt_d;
  logic [QW-1:0]   data_d;
  logic            vld_d, last_d, err_d;
  logic [CW-1:0]   pkt_d;
  logic            out_free;
  logic            in_vld, in_last, acc;
  logic [QW-1:0]   in_data;

  // Output register can take a beat when empty or being drained this cycle
  assign out_free = !m_vld | m_rdy;
  assign s0_rdy   = s_rst_n & (state_q == S0) & out_free;
  assign s1_rdy   = s_rst_n & (state_q == S1) & out_free;
  assign sel      = (state_q == S1);

  // Next-state and output-register update
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt;
    data_d     = m_data;
    vld_d      = m_vld;
    last_d     = m_last;
    err_d      = 1'b0;
    pkt_d      = pkt_cnt;

    in_vld  = (state_q == S1) ? s1_vld  : s0_vld;
    in_last = (state_q == S1) ? s1_last : s0_last;
    in_data = (state_q == S1) ? s1_data : s0_data;
    acc     = in_vld & out_free;

    if (acc) begin
      data_d = in_data;
      last_d = in_last;
      vld_d  = 1'b1;
      if (in_last) begin
        state_d    = (state_q == S0) ? S1 : S0;
        pkt_d      = pkt_cnt + CW'(1);
        beat_cnt_d = '0;
        err_d      = (beat_cnt != BW'(N - 1));
      end else if (beat_cnt == BW'(N - 1)) begin
        // Overlong packet: hold the count and keep draining until last
        err_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt + BW'(1);
      end
    end else if (m_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q  <= S0;
      beat_cnt <= '0;
      m_data   <= '0;
      m_vld    <= 1'b0;
      m_last   <= 1'b0;
      err_len  <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      beat_cnt <= beat_cnt_d;
      m_data   <= data_d;
      m_vld    <= vld_d;
      m_last   <= last_d;
      err_len  <= err_d;
      pkt_cnt  <= pkt_d;
    end
  end

endmodule

// File: tb/tb_axis_pingpong_merge.sv
// Bench for axis_pingpong_merge: per-input packet queues drive the DUT, and a
// packet-level model predicts readies, output beats, length errors and counts.
module tb_axis_pingpong_merge;

  localparam int unsigned N  = 4;
  localparam int unsigned QW = 64;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          s_rst_n;
  logic [QW-1:0] s0_data, s1_data, m_data;
  logic          s0_vld, s0_last, s0_rdy;
  logic          s1_vld, s1_last, s1_rdy;
  logic          m_vld, m_last, m_rdy;
  logic          sel, err_len;
  logic [CW-1:0] pkt_cnt;

  axis_pingpong_merge #(.N(N), .QW(QW), .CW(CW)) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .s0_data(s0_data), .s0_vld(s0_vld), .s0_last(s0_last), .s0_rdy(s0_rdy),
    .s1_data(s1_data), .s1_vld(s1_vld), .s1_last(s1_last), .s1_rdy(s1_rdy),
    .m_data(m_data), .m_vld(m_vld), .m_last(m_last), .m_rdy(m_rdy),
    .sel(sel), .err_len(err_len), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Pending beats per input: bit QW is the last flag
  logic [QW:0]   q0[$];
  logic [QW:0]   q1[$];
  bit            hold0, hold1;
  int            cyc, start0, start1;

  // Reference model state
  bit            exp_sel, occ, exp_last, exp_err;
  logic [QW-1:0] exp_data;
  logic [CW-1:0] exp_pkt;
  int            idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_pkt(input int which, input int len, input logic [QW-1:0] base, input bit rnd);
    logic [QW:0] w;
    for (int b = 0; b < len; b++) begin
      w[QW]     = (b == len - 1);
      w[QW-1:0] = rnd ? {$urandom, $urandom} : base + QW'(b);
      if (which == 0) q0.push_back(w);
      else            q1.push_back(w);
    end
  endtask

  task automatic model_reset();
    occ = 0; exp_sel = 0; exp_last = 0; exp_err = 0; exp_data = '0;
    exp_pkt = '0; idx = 0; hold0 = 0; hold1 = 0; cyc = 0;
    q0.delete(); q1.delete();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    s_rst_n = 1'b0; s0_vld = 1'b1; s1_vld = 1'b1; m_rdy = 1'b1;
    #1;
    chk("rst_s0_rdy", s0_rdy, 0);
    chk("rst_s1_rdy", s1_rdy, 0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_m_vld", m_vld, 0);
    chk("rst_sel", sel, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_m_data", m_data, 0);
    s_rst_n = 1'b1; s0_vld = 1'b0; s1_vld = 1'b0; m_rdy = 1'b0;
    model_reset();
  endtask

  // One clock: check registered outputs, drive new inputs, check readies, advance model
  task automatic cycle(input int pv, input int pr);
    bit free, acc;
    logic [QW:0] beat;
    @(negedge clk);
    chk("m_vld", m_vld, occ);
    if (occ) begin
      chk("m_data", m_data, exp_data);
      chk("m_last", m_last, exp_last);
    end
    chk("sel", sel, exp_sel);
    chk("err_len", err_len, exp_err);
    chk("pkt_cnt", pkt_cnt, exp_pkt);

    if (!hold0) s0_vld = (q0.size() > 0) && (cyc >= start0) && ($urandom_range(99) < pv);
    if (!hold1) s1_vld = (q1.size() > 0) && (cyc >= start1) && ($urandom_range(99) < pv);
    if (q0.size() > 0) {s0_last, s0_data} = q0[0];
    if (q1.size() > 0) {s1_last, s1_data} = q1[0];
    m_rdy = ($urandom_range(99) < pr);
    #1;
    free = !occ || m_rdy;
    chk("s0_rdy", s0_rdy, !exp_sel && free);
    chk("s1_rdy", s1_rdy, exp_sel && free);

    acc   = (exp_sel ? s1_vld : s0_vld) && free;
    hold0 = s0_vld && !(acc && !exp_sel);
    hold1 = s1_vld && !(acc && exp_sel);
    exp_err = 0;
    if (acc) begin
      beat     = exp_sel ? q1.pop_front() : q0.pop_front();
      exp_data = beat[QW-1:0];
      exp_last = beat[QW];
      occ      = 1;
      if (exp_last) begin
        exp_err = (idx < N - 1);
        idx     = 0;
        exp_sel = !exp_sel;
        exp_pkt = exp_pkt + 1'b1;
      end else begin
        exp_err = (idx >= N - 1);
        idx++;
      end
    end else if (m_rdy) begin
      occ = 0;
    end
    cyc++;
  endtask

  task automatic drain(input int pv, input int pr, input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || occ) && n < budget) begin
      cycle(pv, pr);
      n++;
    end
    if (q0.size() > 0 || q1.size() > 0 || occ) chk("drain_timeout", 1, 0);
    cycle(0, 100);
    cycle(0, 100);
  endtask

  initial begin
    int la, lb;
    s_rst_n = 1'b0; s0_vld = 0; s1_vld = 0; s0_last = 0; s1_last = 0;
    s0_data = '0; s1_data = '0; m_rdy = 0; start0 = 0; start1 = 0;
    model_reset();
    do_reset(3);

    // Back-to-back packets, no stalls, both inputs valid
    push_pkt(0, 4, 64'd10, 0);
    push_pkt(1, 4, 64'd20, 0);
    drain(100, 100, 50);
    chk("pkt_basic", pkt_cnt, 2);

    // Input 1 valid early, input 0 late: input 0 must still go first
    do_reset(2);
    push_pkt(0, 4, 64'h100, 0);
    push_pkt(1, 4, 64'h200, 0);
    start0 = 5;
    drain(100, 100, 60);
    start0 = 0;
    chk("pkt_order", pkt_cnt, 2);

    // Output backpressure
    push_pkt(0, 4, '0, 1);
    push_pkt(1, 4, '0, 1);
    drain(100, 50, 200);

    // Short then normal packet
    push_pkt(0, 3, 64'h300, 0);
    push_pkt(1, 4, 64'h400, 0);
    drain(100, 100, 50);

    // Long then normal packet
    push_pkt(0, 5, 64'h500, 0);
    push_pkt(1, 4, 64'h600, 0);
    drain(100, 100, 50);

    // Reset after two beats of a packet, then a fresh exchange
    push_pkt(0, 4, 64'h700, 0);
    cycle(100, 100);
    cycle(100, 100);
    do_reset(2);
    push_pkt(0, 4, 64'h800, 0);
    push_pkt(1, 4, 64'h900, 0);
    drain(100, 100, 50);
    chk("pkt_after_rst", pkt_cnt, 2);

    // Random lengths, random valid gaps and backpressure
    for (int k = 0; k < 30; k++) begin
      la = ($urandom_range(9) < 6) ? N : $urandom_range(N + 2, 1);
      lb = ($urandom_range(9) < 6) ? N : $urandom_range(N + 2, 1);
      push_pkt(0, la, '0, 1);
      push_pkt(1, lb, '0, 1);
    end
    drain(70, 70, 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
